pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
//
// PURPOSE
// - Parametrised pipeline-stage register. Successor to the fixed-width ID/EX latch; one instance per pipeline boundary.
// - Valid/ready handshake on both sides with a 2-entry skid buffer, so back-pressure is registered and never combinational end to end.
// - Synchronous flush kills in-flight entries. Control bits read as zero (a NOP) whenever the output is not valid.
//
// PARAMETERS
// - DATA_W  128  payload width: PC, immediate, rs1/rs2 values, register indices, packed by the instantiator.
// - CTRL_W  11   control-bundle width; forced to 0 on bubbles and on flush.
// - CNT_W   16   width of each perf counter (used only with PIPE_STAGE_PERF_EN).
//
// PORTS
// - clk        in   1       rising-edge clock
// - clr_n      in   1       reset; synchronous, active-low
// - flush      in   1       synchronous kill of all held entries
// - in_valid   in   1       upstream entry present
// - in_ready   out  1       stage can accept an entry this cycle
// - in_ctrl    in   CTRL_W  upstream control bundle
// - in_data    in   DATA_W  upstream payload
// - out_valid  out  1       entry presented downstream
// - out_ready  in   1       downstream accepts this cycle
// - out_ctrl   out  CTRL_W  presented control; all-zero when out_valid=0
// - out_data   out  DATA_W  presented payload
// - occupancy  out  2       held entries (0..2)
// - stall_cnt  out  CNT_W   cycles with out_valid & !out_ready
// - bubble_cnt out  CNT_W   cycles with !out_valid & !flush
//
// BEHAVIOUR
// - Storage: main reg M (ctrl+data) and skid reg S. State is one of EMPTY, ONE, TWO.
// - Outputs from state:
//   - occupancy = 0/1/2 for EMPTY/ONE/TWO.
//   - out_valid = (state != EMPTY); out_data = M.data.
//   - out_ctrl = out_valid ? M.ctrl : 0.
//   - in_ready = (state != TWO) & ~flush. No combinational path from out_ready to in_ready.
// - Transfer events: push = in_valid & in_ready; pop = out_valid & out_ready.
// - Transitions (priority order: clr_n=0, then flush, then the table):
//   - EMPTY: push -> ONE, M<=in.
//   - ONE: push&!pop -> TWO, S<=in. push&pop -> ONE, M<=in. !push&pop -> EMPTY. Neither -> hold.
//   - TWO: pop -> ONE, M<=S. No push is possible because in_ready=0.
// - Ordering is strict FIFO: S always holds the younger entry.
// - Latency: a push into EMPTY appears on out_* in the next cycle.
// - Throughput: 1 entry/cycle while out_ready stays high.
// - Flush, when clr_n=1:
//   - Next state EMPTY; M.ctrl and S.ctrl <= 0; data registers hold their value.
//   - The input offered in the flush cycle is dropped (in_ready=0).
//   - A pop in the flush cycle is still a valid transfer; downstream saw the entry.
//   - Flush in any state, including TWO, empties the stage in one cycle.
// - Reset (clr_n=0 at a clk edge):
//   - state<=EMPTY; M, S <= 0; counters <= 0.
//   - Outputs after reset: out_valid=0, out_ctrl=0, out_data=0, in_ready=1 (when flush=0), occupancy=0.
//   - Reset mid-transfer discards every held entry; no partial update.
// - Simultaneous push and pop in ONE replaces M in the same edge; occupancy stays 1.
//
// CONFIGURATION
// - Macro PIPE_STAGE_PERF_EN.
// - Defined:
//   - stall_cnt increments each cycle with out_valid & !out_ready.
//   - bubble_cnt increments each cycle with !out_valid & !flush.
//   - Both saturate at 2^CNT_W-1; both clear only on reset.
// - Undefined: counter logic is absent; stall_cnt and bubble_cnt tie to 0. Ports are retained.
//
// TESTING
// - Reset: clr_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0; in_ready=1 once clr_n=1.
// - Streaming: out_ready=1; push A..D (data=0x1..0x4) on consecutive cycles -> out_data=0x1..0x4 on the next consecutive cycles, no gaps.
// - Back-pressure: out_ready=0; push 0xA then 0xB -> occupancy=2, in_ready=0.
//   Then out_ready=1 -> 0xA, then 0xB, then out_valid=0.
// - Flush: occupancy=2 with ctrl=0x7FF in both entries; flush=1 for one cycle -> next cycle occupancy=0, out_ctrl=0.
//   The input offered during the flush cycle never appears.
// - Simultaneous: occupancy=1 holding 0x5; push 0x6 with out_ready=1 -> 0x5 popped; next cycle out_data=0x6, occupancy=1.
// - Perf (macro on, CNT_W=2): hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=3 (saturated). Macro off -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid
//
// Parametrised pipeline-stage register with a two-entry skid buffer. One
// instance sits on each pipeline boundary. It uses a valid/ready handshake on
// both sides. Back-pressure is registered: in_ready depends only on the held
// state and on flush, never on out_ready. Entries leave in strict FIFO order.
//
// When the stage presents no entry, out_ctrl reads all-zero, so downstream
// logic sees a NOP.
//
// Optional feature: define PIPE_STAGE_PERF_EN to build the saturating stall
// and bubble counters. When the macro is undefined, both counter ports are
// tied to zero.
//
// Ports
//   clk         rising-edge clock
//   clr_n       synchronous, active-low reset
//   flush       synchronous kill of all held entries; blocks input that cycle
//   in_valid    upstream entry present
//   in_ready    stage can accept an entry this cycle
//   in_ctrl     upstream control bundle (CTRL_W)
//   in_data     upstream payload (DATA_W)
//   out_valid   entry presented downstream
//   out_ready   downstream accepts this cycle
//   out_ctrl    presented control bundle, zero when out_valid=0
//   out_data    presented payload
//   occupancy   number of held entries (0..2)
//   stall_cnt   cycles with out_valid & !out_ready (saturating)
//   bubble_cnt  cycles with !out_valid & !flush (saturating)
// ----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              push;
    logic              pop;

    // Handshake signals are decoded from the state register only. Because
    // in_ready never looks at out_ready, no combinational path runs through
    // the stage from downstream back to upstream.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != TWO) && !flush;
    assign out_data  = m_data;
    assign out_ctrl  = out_valid ? m_ctrl : '0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // NOTE: give every combinational output a default before the case. A path
    // that leaves an output unassigned infers a latch.
    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // M is always the older entry and S the younger one. When S is occupied
    // and M pops, S moves forward into M.
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together at the edge, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            // NOTE: the payload registers are reset too, not only the state.
            // This makes out_data read zero after reset instead of stale data.
            state  <= EMPTY;
            m_ctrl <= '0;
            m_data <= '0;
            s_ctrl <= '0;
            s_data <= '0;
        end else if (flush) begin
            // Killing the control bits turns any stale entry into a NOP. The
            // data registers keep their contents to save enable fan-out.
            state  <= EMPTY;
            m_ctrl <= '0;
            s_ctrl <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state  <= ONE;
                        m_ctrl <= in_ctrl;
                        m_data <= in_data;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state  <= TWO;
                        s_ctrl <= in_ctrl;
                        s_data <= in_data;
                    end else if (push && pop) begin
                        // M drains and refills on the same edge, so
                        // occupancy stays at one.
                        m_ctrl <= in_ctrl;
                        m_data <= in_data;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state  <= ONE;
                        m_ctrl <= s_ctrl;
                        m_data <= s_data;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Both counters stick at all-ones. Only reset clears them; flush does not.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + 1'b1;
            if (!out_valid && !flush && (bubble_q != {CNT_W{1'b1}}))
                bubble_q <= bubble_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int DW      = 128;
    localparam int CW      = 11;
    localparam int NW      = 16;
    localparam int CNT_MAX = (1 << NW) - 1;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          clr_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cnt, bubble_cnt;

    // Second, narrow instance with CNT_W=2, so the counters can reach
    // saturation within a few cycles.
    logic       p_clr_n, p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [2:0] p_in_ctrl, p_out_ctrl;
    logic [7:0] p_in_data, p_out_data;
    logic [1:0] p_occupancy, p_stall_cnt, p_bubble_cnt;

    int     n_cmp = 0;
    int     n_bad = 0;
    entry_t exp_q[$];   // entries the model says are held, oldest first
    int     held_now = 0;
    bit     mon_en = 1'b0;
    bit     perf_done = 1'b0;
    int     stall_m = 0;
    int     bubble_m = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .clr_n(clr_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.DATA_W(8), .CTRL_W(3), .CNT_W(2)) dut_perf (
        .clk(clk), .clr_n(p_clr_n), .flush(p_flush),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_ctrl(p_in_ctrl), .in_data(p_in_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_ctrl(p_out_ctrl), .out_data(p_out_data),
        .occupancy(p_occupancy), .stall_cnt(p_stall_cnt), .bubble_cnt(p_bubble_cnt)
    );

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Drives one cycle of stimulus. If the stage is expected to accept the
    // offered entry, it goes onto the scoreboard.
    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic rdy, input logic fl, input logic cl);
        entry_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
        clr_n     = cl;
        held_now  = exp_q.size();
        if (cl && v && !fl && held_now < 2) begin
            e.ctrl = c;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compares what is presented against the oldest held entry, then
    // advances the model by the pop, flush and reset of this cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", in_ready, (held_now < 2) && !flush);
            check("occupancy", occupancy, held_now);
            check("out_valid", out_valid, held_now > 0);
            if (held_now > 0) begin
                check("out_data", out_data, exp_q[0].data);
                check("out_ctrl", out_ctrl, exp_q[0].ctrl);
            end else begin
                check("out_ctrl_nop", out_ctrl, 0);
            end
`ifdef PIPE_STAGE_PERF_EN
            check("stall_cnt", stall_cnt, stall_m);
            check("bubble_cnt", bubble_cnt, bubble_m);
`else
            check("stall_cnt_off", stall_cnt, 0);
            check("bubble_cnt_off", bubble_cnt, 0);
`endif
            if (!clr_n) begin
                exp_q.delete();
                stall_m  = 0;
                bubble_m = 0;
            end else begin
                if (held_now > 0 && out_ready && stall_m < CNT_MAX && 1'b0) stall_m++;
                if (held_now > 0 && !out_ready && stall_m < CNT_MAX) stall_m++;
                if (held_now == 0 && !flush && bubble_m < CNT_MAX) bubble_m++;
                if (held_now > 0 && out_ready) void'(exp_q.pop_front());
                if (flush) exp_q.delete();
            end
        end
    end

    // Counter saturation on the narrow instance.
    initial begin
        p_clr_n = 1'b0; p_flush = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b0;
        p_in_ctrl = 3'h5; p_in_data = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        p_clr_n = 1'b1; p_in_valid = 1'b1;      // empty cycle -> one bubble
        @(posedge clk);
        #1;
        p_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`ifdef PIPE_STAGE_PERF_EN
        check("perf_stall_2", p_stall_cnt, 2);
`else
        check("perf_stall_2_off", p_stall_cnt, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("perf_out_data", p_out_data, 8'h5A);
        check("perf_out_ctrl", p_out_ctrl, 3'h5);
`ifdef PIPE_STAGE_PERF_EN
        check("perf_stall_sat", p_stall_cnt, 3);
        check("perf_bubble", p_bubble_cnt, 1);
`else
        check("perf_stall_sat_off", p_stall_cnt, 0);
        check("perf_bubble_off", p_bubble_cnt, 0);
`endif
        perf_done = 1'b1;
    end

    initial begin
        // Reset held for two edges while an entry is offered.
        clr_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_ctrl = 11'h7FF; in_data = {4{32'hDEADBEEF}};
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_data", out_data, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_bubble", bubble_cnt, 0);
        clr_n = 1'b1; in_valid = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        held_now = 0;
        mon_en = 1'b1;

        // Streaming
        for (int i = 1; i <= 4; i++) drive(1, CW'(i), DW'(i), 1, 0, 1);
        repeat (2) drive(0, 0, 0, 1, 0, 1);

        // Back-pressure
        drive(1, 11'h00A, 'hA, 0, 0, 1);
        drive(1, 11'h00B, 'hB, 0, 0, 1);
        drive(1, 11'h00C, 'hC, 0, 0, 1);        // refused: stage full
        repeat (3) drive(0, 0, 0, 1, 0, 1);

        // Flush while full; the entry offered in the flush cycle is dropped
        drive(1, 11'h7FF, 'h11, 0, 0, 1);
        drive(1, 11'h7FF, 'h22, 0, 0, 1);
        drive(1, 11'h123, 'h33, 0, 1, 1);
        repeat (2) drive(0, 0, 0, 1, 0, 1);

        // Simultaneous push and pop with one entry held
        drive(1, 11'h055, 'h5, 0, 0, 1);
        drive(1, 11'h066, 'h6, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 1);

        // Reset with two entries in flight
        drive(1, 11'h101, 'h71, 0, 0, 1);
        drive(1, 11'h102, 'h72, 0, 0, 1);
        drive(1, 11'h103, 'h73, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, CW'($urandom),
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 99) != 0);
        end
        repeat (3) drive(0, 0, 0, 1, 0, 1);

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        wait (perf_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
